// File: rtl/sa_sync_tx_hs.sv
// Transmit half of a toggle req/ack CDC handshake: launches a held word plus a
// level-toggle request and retires it once the synchronized acknowledge matches.
module sa_sync_tx_hs #(
   parameter int unsigned DW          = 32,
   parameter int unsigned SYNC_STAGES = 3,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          src_valid,
   output logic          src_ready,
   input  logic [DW-1:0] src_data,
   output logic          tx_req,
   output logic [DW-1:0] tx_data,
   input  logic          rx_ack,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [15:0]   xfer_cnt
);

   typedef enum logic [1:0] {IDLE, LOAD, WAIT_ACK} state_t;

   localparam logic [15:0] TMO = 16'(TIMEOUT_CYC);

   state_t                 state_q, state_d;
   logic                   tx_req_q, tx_req_d;
   logic [DW-1:0]          tx_data_q, tx_data_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   done_q, done_d;
   logic                   err_q, err_d;
   logic [15:0]            xfer_cnt_q, xfer_cnt_d;
   logic [15:0]            wcnt_q, wcnt_d;
   logic                   ack_s;

   assign ack_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d    = state_q;
      tx_req_d   = tx_req_q;
      tx_data_d  = tx_data_q;
      wcnt_d     = wcnt_q;
      done_d     = 1'b0;
      err_d      = err_q;
      xfer_cnt_d = xfer_cnt_q;
      case (state_q)
         IDLE: begin
            if (src_valid) begin
               tx_data_d = src_data;
               state_d   = LOAD;
            end
         end
         LOAD: begin
            // data was registered one cycle earlier, so it is settled before req flips
            tx_req_d = ~tx_req_q;
            wcnt_d   = '0;
            state_d  = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (ack_s == tx_req_q) begin
               state_d    = IDLE;
               done_d     = 1'b1;
               xfer_cnt_d = xfer_cnt_q + 16'd1;
            end else begin
               // keep waiting after a timeout: aborting would break toggle parity
               if (wcnt_q != TMO) wcnt_d = wcnt_q + 16'd1;
               if (wcnt_d == TMO) err_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= IDLE;
         tx_req_q   <= 1'b0;
         tx_data_q  <= '0;
         sync_q     <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         xfer_cnt_q <= '0;
         wcnt_q     <= '0;
      end else begin
         state_q    <= state_d;
         tx_req_q   <= tx_req_d;
         tx_data_q  <= tx_data_d;
         sync_q     <= {sync_q[SYNC_STAGES-2:0], rx_ack};
         done_q     <= done_d;
         err_q      <= err_d;
         xfer_cnt_q <= xfer_cnt_d;
         wcnt_q     <= wcnt_d;
         // an ack toggle outside WAIT_ACK is a receiver protocol violation
         assert (state_q == WAIT_ACK || ack_s == tx_req_q);
      end
   end

   assign src_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign tx_req    = tx_req_q;
   assign tx_data   = tx_data_q;
   assign done      = done_q;
   assign err       = err_q;
   assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_sa_sync_tx_hs.sv
// Directed scoreboard bench for sa_sync_tx_hs (SYNC_STAGES=3, TIMEOUT_CYC=16).
module tb_sa_sync_tx_hs;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rstn, src_valid, src_ready, tx_req, rx_ack, busy, done, err;
   logic [DW-1:0] src_data, tx_data;
   logic [15:0]   xfer_cnt;

   int checks = 0;
   int passed = 0;
   int cyc    = 0;

   typedef struct packed {
      logic [31:0] data;
      logic [15:0] cnt;
      logic        par;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] m_cnt;
   logic        m_par;

   sa_sync_tx_hs #(.DW(DW), .SYNC_STAGES(3), .TIMEOUT_CYC(16)) dut (
      .clk(clk), .rstn(rstn), .src_valid(src_valid), .src_ready(src_ready),
      .src_data(src_data), .tx_req(tx_req), .tx_data(tx_data), .rx_ack(rx_ack),
      .busy(busy), .done(done), .err(err), .xfer_cnt(xfer_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic push(input logic [31:0] w);
      exp_t e;
      e.data = w;
      e.cnt  = m_cnt + 16'd1;
      e.par  = ~m_par;
      sb.push_back(e);
      m_cnt  = e.cnt;
      m_par  = e.par;
   endtask

   task automatic retire_check(input string tag);
      exp_t e;
      chk({tag, "_sb"}, 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_data"}, 64'(tx_data), 64'(e.data));
         chk({tag, "_cnt"}, 64'(xfer_cnt), 64'(e.cnt));
         chk({tag, "_req"}, 64'(tx_req), 64'(e.par));
         chk({tag, "_rdy"}, 64'(src_ready), 64'd1);
      end
   endtask

   task automatic wait_done(input string tag, input logic [31:0] w, output int n);
      logic got;
      got = 1'b0;
      n   = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         tick();
         n++;
         if (done) got = 1'b1;
         else chk({tag, "_hold"}, 64'(tx_data), 64'(w));
      end
      chk({tag, "_seen"}, 64'(got), 64'd1);
      if (got) retire_check(tag);
   endtask

   task automatic do_xfer(input string tag, input logic [31:0] w);
      int n;
      src_valid = 1'b1;
      src_data  = w;
      tick();
      src_valid = 1'b0;
      push(w);
      chk({tag, "_ld"}, 64'(tx_data), 64'(w));
      tick();
      chk({tag, "_tog"}, 64'(tx_req), 64'(m_par));
      repeat (4) tick();
      rx_ack = ~rx_ack;
      wait_done(tag, w, n);
   endtask

   initial begin
      int          n;
      int          last_acc;
      logic        rdy, got;
      logic [31:0] w;

      rstn      = 1'b0;
      src_valid = 1'b1;
      src_data  = 32'hDEADBEEF;
      rx_ack    = 1'b0;
      m_cnt     = '0;
      m_par     = 1'b0;
      last_acc  = 0;

      // reset held two cycles with src_valid high
      tick();
      tick();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_cnt", 64'(xfer_cnt), 64'd0);
      chk("rst_req", 64'(tx_req), 64'd0);
      chk("rst_data", 64'(tx_data), 64'd0);
      rstn      = 1'b1;
      src_valid = 1'b0;
      tick();
      chk("post_rdy", 64'(src_ready), 64'd1);
      chk("post_busy", 64'(busy), 64'd0);

      // single transfer with exact handshake timing
      src_valid = 1'b1;
      src_data  = 32'hA5A5_0001;
      tick();
      src_valid = 1'b0;
      push(32'hA5A5_0001);
      chk("s_data", 64'(tx_data), 64'hA5A5_0001);
      chk("s_req0", 64'(tx_req), 64'd0);
      chk("s_rdy0", 64'(src_ready), 64'd0);
      tick();
      chk("s_req1", 64'(tx_req), 64'd1);
      repeat (4) tick();
      rx_ack = ~rx_ack;
      wait_done("s", 32'hA5A5_0001, n);
      chk("s_lat", 64'(n), 64'd4);
      tick();
      chk("s_done_lo", 64'(done), 64'd0);

      // back-to-back with src_valid held high
      src_valid = 1'b1;
      src_data  = 32'h1;
      for (int k = 0; k < 3; k++) begin
         got = 1'b0;
         for (int i = 0; i < 40 && !got; i++) begin
            rdy = src_ready;
            tick();
            if (rdy) got = 1'b1;
         end
         chk("b2b_acc", 64'(got), 64'd1);
         if (k > 0) chk("b2b_space", 64'(cyc - last_acc), 64'd10);
         last_acc = cyc;
         w = 32'(k + 1);
         push(w);
         src_data = 32'(k + 2);
         chk("b2b_data", 64'(tx_data), 64'(w));
         tick();
         chk("b2b_req", 64'(tx_req), 64'(m_par));
         repeat (4) tick();
         rx_ack = ~rx_ack;
         wait_done("b2b", w, n);
      end
      src_valid = 1'b0;
      chk("b2b_cnt", 64'(xfer_cnt), 64'(m_cnt));

      // ack timeout, then late ack
      src_valid = 1'b1;
      src_data  = 32'hC0DE_0005;
      tick();
      src_valid = 1'b0;
      push(32'hC0DE_0005);
      tick();
      repeat (15) tick();
      chk("to_err_pre", 64'(err), 64'd0);
      tick();
      chk("to_err", 64'(err), 64'd1);
      chk("to_busy", 64'(busy), 64'd1);
      repeat (5) tick();
      chk("to_busy_hold", 64'(busy), 64'd1);
      chk("to_data_hold", 64'(tx_data), 64'hC0DE_0005);
      rx_ack = ~rx_ack;
      wait_done("to", 32'hC0DE_0005, n);
      chk("to_err_sticky", 64'(err), 64'd1);

      // reset during WAIT_ACK abandons the transfer
      src_valid = 1'b1;
      src_data  = 32'hBADC_0FFE;
      tick();
      src_valid = 1'b0;
      tick();
      repeat (3) tick();
      rstn   = 1'b0;
      rx_ack = 1'b0;
      tick();
      chk("mr_busy", 64'(busy), 64'd0);
      chk("mr_rdy", 64'(src_ready), 64'd1);
      chk("mr_req", 64'(tx_req), 64'd0);
      chk("mr_data", 64'(tx_data), 64'd0);
      chk("mr_err", 64'(err), 64'd0);
      chk("mr_cnt", 64'(xfer_cnt), 64'd0);
      chk("mr_done", 64'(done), 64'd0);
      rstn = 1'b1;
      sb.delete();
      m_cnt = '0;
      m_par = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("mr_nodone", 64'(done), 64'd0);
      end

      // counter wrap with odd parity carried into the preload
      do_xfer("wr1", 32'h1111_0001);
      force dut.xfer_cnt_q = 16'hFFFF;
      tick();
      release dut.xfer_cnt_q;
      m_cnt = 16'hFFFF;
      tick();
      chk("wr_pre", 64'(xfer_cnt), 64'hFFFF);
      do_xfer("wr2", 32'h1111_0002);
      chk("wr_cnt", 64'(xfer_cnt), 64'd0);
      chk("wr_par", 64'(tx_req), 64'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/sa_sync_tx_hs.md
Name: sa_sync_tx_hs

Overview:
- Source-domain (transmitter) half of a toggle req/ack clock-domain-crossing handshake.
- Accepts a DW-bit word through a valid/ready interface and launches it to a destination-domain receiver as a held data bus plus a level-toggle request.
- Synchronizes the receiver's returned toggle acknowledge into clk with an internal multi-flop synchronizer, then retires the transfer.
- Single clock; the destination-side receiver is a separate block.

Parameters:
- DW, 32, width of transferred data word.
- SYNC_STAGES, 3, flops in the rx_ack synchronizer chain; legal range 2..4.
- TIMEOUT_CYC, 1024, WAIT_ACK cycle count at which err asserts; legal range 1..65535.

Ports:
- clk  input  1  core clock; all state on rising edge.
- rstn  input  1  synchronous active-low reset, sampled on rising clk.
- src_valid  input  1  source word valid.
- src_ready  output  1  block can accept a word.
- src_data  input  DW  source word.
- tx_req  output  1  level-toggle request to the destination domain; registered.
- tx_data  output  DW  launched word; registered; stable while a transfer is in flight.
- rx_ack  input  1  asynchronous toggle acknowledge from the destination.
- busy  output  1  transfer in flight (state != IDLE).
- done  output  1  one-cycle pulse on transfer retirement.
- err  output  1  sticky ack-timeout flag.
- xfer_cnt  output  16  count of retired transfers; wraps.

Behaviour:
- Reset (rstn=0 at a rising edge):
  - state=IDLE; tx_req=0; tx_data=0; synchronizer flops=0.
  - done=0; err=0; xfer_cnt=0; wait counter=0.
  - src_ready=1 from the first cycle after reset.
  - Reset mid-transfer abandons the transfer with no completion. The system resets the destination receiver in the same reset event.
- Ack synchronizer: SYNC_STAGES-deep flop chain on rx_ack; ack_s = last stage. No other logic reads rx_ack.
- src_ready = (state==IDLE), combinational from state.
- FSM states: IDLE, LOAD, WAIT_ACK.
- IDLE:
  - Edge with src_valid & src_ready: tx_data <= src_data; go to LOAD.
  - Otherwise hold.
- LOAD (exactly 1 cycle):
  - tx_req <= ~tx_req; wait counter <= 0; go to WAIT_ACK.
  - tx_data therefore leads the req toggle by one cycle.
- WAIT_ACK:
  - If ack_s == tx_req: go to IDLE; done <= 1 for one cycle; xfer_cnt <= xfer_cnt+1 (mod 2^16).
  - Else: wait counter increments, saturating at TIMEOUT_CYC.
  - When the counter reaches TIMEOUT_CYC: err <= 1, sticky until reset.
  - The transfer keeps waiting after a timeout and is never aborted, because aborting would desynchronize toggle parity.
- tx_data changes only on the IDLE accept edge. It holds through LOAD and WAIT_ACK.
- src_data and src_valid are ignored outside IDLE. No source-side buffering.
- Minimum accept-to-accept spacing: 3 + SYNC_STAGES + destination round-trip cycles.
- Toggle parity: after N retired transfers, tx_req = N mod 2.
- An rx_ack toggle that arrives while in IDLE or LOAD is a protocol violation. Behaviour in that case is undefined; assertions flag it.

Test Plan:
- Reset with rstn=0 for 2 cycles while src_valid=1:
  - tx_req=0, done=0, err=0, xfer_cnt=0, src_ready=1 after release.
  - No accept occurs during reset.
- Single transfer (SYNC_STAGES=3), src_data=0xA5A5_0001 accepted at edge E0; bench toggles rx_ack just after E5:
  - tx_data=0xA5A5_0001 after E0; tx_req=1 after E1.
  - ack_s=1 after E8; done=1 and src_ready=1 for cycle after E9; xfer_cnt=1.
- Back-to-back: src_valid held high with words 0x1, 0x2, 0x3 and a 4-cycle bench ack delay:
  - Accepts spaced exactly 10 cycles apart.
  - tx_req sequence 1,0,1; xfer_cnt=3.
  - tx_data never changes while busy=1.
- Timeout with TIMEOUT_CYC=16 and rx_ack never toggled:
  - err rises 16 cycles into WAIT_ACK and busy stays 1.
  - Later ack toggle retires the transfer (done pulse); err remains 1.
- Reset mid-WAIT_ACK at cycle 4 of the wait: all outputs return to reset values next cycle; no done pulse.
- Wrap: preload 65535 completions (force or long run), then one more transfer: xfer_cnt=0; tx_req parity = 0.
